// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Optional build macro CLK_DIV_PHASE_EN adds a per-channel programmable restart phase.
package clk_div_pkg;

    localparam int unsigned DFLT_N_CH      = 4;
    localparam int unsigned DFLT_DIV_WIDTH = 12;
    localparam int unsigned DFLT_PERIOD    = 9;
    localparam int unsigned DFLT_HIGH      = 5;

    // Channel-index width; a single-channel build still gets a 1-bit select.
    function automatic int unsigned ch_idx_w(input int unsigned n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, active/shadow config, pending flag, terminal count and output compare.
// With CLK_DIV_PHASE_EN defined, restarts load min(phase, period) instead of 0.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_WIDTH  = DFLT_DIV_WIDTH,
    parameter int unsigned DEF_PERIOD = DFLT_PERIOD,
    parameter int unsigned DEF_HIGH   = DFLT_HIGH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 sync,
    input  logic                 wr,
    input  logic [DIV_WIDTH-1:0] cfg_period,
    input  logic [DIV_WIDTH-1:0] cfg_high,
`ifdef CLK_DIV_PHASE_EN
    input  logic [DIV_WIDTH-1:0] cfg_phase,
`endif
    output logic                 clk_out,
    output logic                 tc,
    output logic                 pend
);

    typedef struct packed {
        logic [DIV_WIDTH-1:0] period;
        logic [DIV_WIDTH-1:0] high;
`ifdef CLK_DIV_PHASE_EN
        logic [DIV_WIDTH-1:0] phase;
`endif
    } cfg_t;

    logic [DIV_WIDTH-1:0] cnt, cnt_nxt, load_val;
    cfg_t                 act, act_nxt, shd, shd_nxt;
    logic                 en_d, restart, wrap, apply;

    always_comb begin
        restart = en && (sync || !en_d);
        wrap    = en && (cnt == act.period);
        apply   = !en || restart || wrap;
        // Apply always takes the shadow as it stood before this cycle's write.
        act_nxt = apply ? shd : act;

`ifdef CLK_DIV_PHASE_EN
        load_val = (act_nxt.phase < act_nxt.period) ? act_nxt.phase : act_nxt.period;
`else
        load_val = '0;
`endif

        if (!en)
            cnt_nxt = '0;
        else if (restart)
            cnt_nxt = load_val;
        else if (wrap)
            cnt_nxt = '0;
        else
            cnt_nxt = cnt + DIV_WIDTH'(1);

        shd_nxt = shd;
        if (wr) begin
            shd_nxt.period = cfg_period;
            shd_nxt.high   = cfg_high;
`ifdef CLK_DIV_PHASE_EN
            shd_nxt.phase  = cfg_phase;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            en_d       <= 1'b0;
            act.period <= DIV_WIDTH'(DEF_PERIOD);
            act.high   <= DIV_WIDTH'(DEF_HIGH);
            shd.period <= DIV_WIDTH'(DEF_PERIOD);
            shd.high   <= DIV_WIDTH'(DEF_HIGH);
`ifdef CLK_DIV_PHASE_EN
            act.phase  <= '0;
            shd.phase  <= '0;
`endif
            pend       <= 1'b0;
            tc         <= 1'b0;
            clk_out    <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            en_d    <= en;
            act     <= act_nxt;
            shd     <= shd_nxt;
            pend    <= wr || (pend && !apply);
            tc      <= wrap && !restart;
            clk_out <= en && (cnt_nxt < act_nxt.high);
        end
    end

endmodule

// File: rtl/clk_div_mc.sv
// Multi-channel programmable clock divider: decodes config writes per channel and fans out sync.
// Optional build macro CLK_DIV_PHASE_EN adds the cfg_phase input.
module clk_div_mc
    import clk_div_pkg::*;
#(
    parameter int unsigned N_CH       = DFLT_N_CH,
    parameter int unsigned DIV_WIDTH  = DFLT_DIV_WIDTH,
    parameter int unsigned DEF_PERIOD = DFLT_PERIOD,
    parameter int unsigned DEF_HIGH   = DFLT_HIGH,
    localparam int unsigned CH_IDX_W  = ch_idx_w(N_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CH-1:0]      en,
    input  logic                 sync,
    input  logic                 cfg_wr,
    input  logic [CH_IDX_W-1:0]  cfg_ch,
    input  logic [DIV_WIDTH-1:0] cfg_period,
    input  logic [DIV_WIDTH-1:0] cfg_high,
`ifdef CLK_DIV_PHASE_EN
    input  logic [DIV_WIDTH-1:0] cfg_phase,
`endif
    output logic [N_CH-1:0]      clk_out,
    output logic [N_CH-1:0]      tc,
    output logic [N_CH-1:0]      pend
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic wr;
        // Only indices 0..N_CH-1 decode, so out-of-range writes fall through.
        assign wr = cfg_wr && (cfg_ch == CH_IDX_W'(i));

        clk_div_ch #(
            .DIV_WIDTH  (DIV_WIDTH),
            .DEF_PERIOD (DEF_PERIOD),
            .DEF_HIGH   (DEF_HIGH)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en[i]),
            .sync       (sync),
            .wr         (wr),
            .cfg_period (cfg_period),
            .cfg_high   (cfg_high),
`ifdef CLK_DIV_PHASE_EN
            .cfg_phase  (cfg_phase),
`endif
            .clk_out    (clk_out[i]),
            .tc         (tc[i]),
            .pend       (pend[i])
        );
    end

endmodule

// File: tb/tb_clk_div_mc.sv
// Scoreboard bench for clk_div_mc: a per-channel behavioural model predicts outputs for each cycle.
module tb_clk_div_mc;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 12;
    localparam int unsigned DP = 9;
    localparam int unsigned DH = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] en = '0;
    logic         sync = 1'b0;
    logic         cfg_wr = 1'b0;
    logic [1:0]   cfg_ch = '0;
    logic [W-1:0] cfg_period = '0;
    logic [W-1:0] cfg_high = '0;
    logic [W-1:0] cfg_phase = '0;
    logic [N-1:0] clk_out, tc, pend;

    clk_div_mc #(
        .N_CH       (N),
        .DIV_WIDTH  (W),
        .DEF_PERIOD (DP),
        .DEF_HIGH   (DH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .sync       (sync),
        .cfg_wr     (cfg_wr),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
`ifdef CLK_DIV_PHASE_EN
        .cfg_phase  (cfg_phase),
`endif
        .clk_out    (clk_out),
        .tc         (tc),
        .pend       (pend)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] co;
        logic [N-1:0] t;
        logic [N-1:0] pd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: position in period, active/shadow settings, pending, previously enabled.
    int unsigned pos[N], pa[N], ha[N], pha[N], ps[N], hs[N], phs[N];
    bit          pdm[N], was_en[N];

    task automatic model_step();
        exp_t x;
        x = '0;
        for (int i = 0; i < N; i++) begin
            bit wr, rs, fin, adopt;
            int unsigned ld;
            wr = cfg_wr && (int'(cfg_ch) == i);
            rs = 1'b0;
            fin = 1'b0;
            if (!rst_n) begin
                pos[i] = 0; pa[i] = DP; ps[i] = DP; ha[i] = DH; hs[i] = DH;
                pha[i] = 0; phs[i] = 0; pdm[i] = 0; was_en[i] = 0;
                continue;
            end
            if (en[i]) begin
                rs  = sync || !was_en[i];
                fin = (pos[i] == pa[i]);
            end
            adopt = !en[i] || rs || fin;
            if (adopt) begin
                pa[i] = ps[i]; ha[i] = hs[i]; pha[i] = phs[i];
            end
`ifdef CLK_DIV_PHASE_EN
            ld = (pha[i] < pa[i]) ? pha[i] : pa[i];
`else
            ld = 0;
`endif
            if (!en[i])   pos[i] = 0;
            else if (rs)  pos[i] = ld;
            else if (fin) pos[i] = 0;
            else          pos[i] = pos[i] + 1;
            x.co[i] = en[i] && (pos[i] < ha[i]);
            x.t[i]  = fin && !rs;
            pdm[i]  = wr ? 1'b1 : (adopt ? 1'b0 : pdm[i]);
            x.pd[i] = pdm[i];
            if (wr) begin
                ps[i] = int'(cfg_period); hs[i] = int'(cfg_high); phs[i] = int'(cfg_phase);
            end
            was_en[i] = en[i];
        end
        q.push_back(x);
    endtask

    task automatic drive(input logic r, input logic [N-1:0] e, input logic s, input logic w,
                         input logic [1:0] c, input int unsigned p, input int unsigned h,
                         input int unsigned ph);
        @(posedge clk);
        #2;
        rst_n = r; en = e; sync = s; cfg_wr = w; cfg_ch = c;
        cfg_period = W'(p); cfg_high = W'(h); cfg_phase = W'(ph);
        model_step();
    endtask

    task automatic idle(input logic [N-1:0] e, input int unsigned n);
        for (int k = 0; k < int'(n); k++) drive(1'b1, e, 1'b0, 1'b0, 2'd0, 0, 0, 0);
    endtask

    task automatic cmp(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                cmp("clk_out", clk_out, x.co);
                cmp("tc", tc, x.t);
                cmp("pend", pend, x.pd);
            end
        end
    end

    initial begin : stim
        bit found;
        #1 rst_n = 1'b0;
        #2;
        cmp("reset_clk_out", clk_out, '0);
        cmp("reset_tc", tc, '0);
        cmp("reset_pend", pend, '0);
        drive(1'b0, '0, 1'b0, 1'b0, 2'd0, 0, 0, 0);
        drive(1'b0, '0, 1'b0, 1'b0, 2'd0, 0, 0, 0);

        // Default divide on ch0: 10-cycle period, 5 high.
        idle(4'b0001, 25);

        // Reprogram ch1 while running; takes effect at its next wrap.
        idle(4'b0011, 12);
        drive(1'b1, 4'b0011, 1'b0, 1'b1, 2'd1, 3, 1, 0);
        idle(4'b0011, 25);

        // Write ch2 exactly on its wrap cycle.
        idle(4'b0111, 3);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (pos[2] == pa[2]) found = 1'b1;
            else idle(4'b0111, 1);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL collision_setup: got no wrap expected wrap within 20 cycles");
        end
        drive(1'b1, 4'b0111, 1'b0, 1'b1, 2'd2, 4, 2, 0);
        idle(4'b0111, 25);

        // Periods 9,4,2,0 then a common sync.
        drive(1'b1, 4'b1111, 1'b0, 1'b1, 2'd0, 9, 5, 0);
        drive(1'b1, 4'b1111, 1'b0, 1'b1, 2'd1, 4, 2, 0);
        drive(1'b1, 4'b1111, 1'b0, 1'b1, 2'd2, 2, 1, 0);
        drive(1'b1, 4'b1111, 1'b0, 1'b1, 2'd3, 0, 1, 0);
        idle(4'b1111, 13);
        drive(1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 0, 0, 0);
        idle(4'b1111, 15);

        // Extreme duty: high 0 and high above period.
        drive(1'b1, 4'b1111, 1'b0, 1'b1, 2'd0, 9, 0, 0);
        drive(1'b1, 4'b1111, 1'b0, 1'b1, 2'd1, 9, 12, 0);
        idle(4'b1111, 25);

`ifdef CLK_DIV_PHASE_EN
        drive(1'b1, 4'b0011, 1'b0, 1'b1, 2'd0, 7, 4, 0);
        drive(1'b1, 4'b0011, 1'b0, 1'b1, 2'd1, 7, 4, 2);
        drive(1'b1, 4'b0011, 1'b1, 1'b0, 2'd0, 0, 0, 0);
        idle(4'b0011, 18);
        drive(1'b1, 4'b0011, 1'b0, 1'b1, 2'd1, 7, 4, 20);
        drive(1'b1, 4'b0011, 1'b1, 1'b0, 2'd0, 0, 0, 0);
        idle(4'b0011, 18);
`endif

        // Mid-operation reset with a write pending.
        drive(1'b1, 4'b1111, 1'b0, 1'b1, 2'd3, 6, 3, 1);
        drive(1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 0, 0, 0);
        idle(4'b1111, 15);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            logic [N-1:0] e;
            for (int b = 0; b < N; b++) e[b] = ($urandom_range(99) < 85);
            drive(($urandom_range(499) != 0), e, ($urandom_range(29) == 0),
                  ($urandom_range(3) == 0), 2'($urandom_range(3)),
                  $urandom_range(11), $urandom_range(13), $urandom_range(15));
        end

        idle(4'b1111, 3);
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d queued expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
